fl_alloc_ctrl: RTL and testbench

FL_ALLOC_CTRL -- requirements
Module: fl_alloc_ctrl

---
 rtl/fl_alloc_ctrl_pkg.sv | 10 +
 rtl/fl_alloc_ctrl_if.sv | 23 ++
 rtl/fl_alloc_ctrl.sv | 64 ++++++
 tb/tb_fl_alloc_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fl_alloc_ctrl_pkg.sv
// fl_alloc_ctrl_pkg: shared sizes and FSM encoding for the free-list allocation controller
package fl_alloc_ctrl_pkg;
    localparam int FL_DEPTH = 64;
    localparam int CNT_W = 7;
    localparam int TAG_W = 7;
    typedef enum logic {
        IDLE = 1'b0,
        RECOVER = 1'b1
    } fl_state_e;
endpackage

// File: rtl/fl_alloc_ctrl_if.sv
// fl_alloc_ctrl_if: dispatch/retire/squash bundle between the pipeline and the free-list controller
interface fl_alloc_ctrl_if #(
    parameter int CNT_W = fl_alloc_ctrl_pkg::CNT_W
);
    logic [1:0] id_req_num;
    logic [1:0] rob_retire_num;
    logic br_mispredict;
    logic [CNT_W-1:0] rob_squash_num;
    logic [1:0] id_dispatch_num;
    logic [1:0] fl_rollback_num;
    logic [CNT_W-1:0] fl_free_count;
    logic id_stall;
    logic fl_recovering;
    logic fl_overflow_err;
    modport master (
        output id_req_num, rob_retire_num, br_mispredict, rob_squash_num,
        input id_dispatch_num, fl_rollback_num, fl_free_count, id_stall, fl_recovering, fl_overflow_err
    );
    modport slave (
        input id_req_num, rob_retire_num, br_mispredict, rob_squash_num,
        output id_dispatch_num, fl_rollback_num, fl_free_count, id_stall, fl_recovering, fl_overflow_err
    );
endinterface

// File: rtl/fl_alloc_ctrl.sv
// fl_alloc_ctrl: grants dispatch allocations from a free count and replays squashed registers back in
module fl_alloc_ctrl #(
    parameter int FL_DEPTH = fl_alloc_ctrl_pkg::FL_DEPTH,
    parameter int CNT_W = fl_alloc_ctrl_pkg::CNT_W
) (
    input logic clock,
    input logic reset,
    fl_alloc_ctrl_if.slave bus
);
    import fl_alloc_ctrl_pkg::*;

    fl_state_e state, state_n;
    logic [CNT_W-1:0] count, rem, rem_n;
    logic err;
    logic [1:0] req_e, ret_e, grant, rb;
    logic [CNT_W:0] cnt_sum, rem_sum;

    // next state, grants, rollback and the widened count/remaining sums
    always_comb begin
        req_e = bus.id_req_num[1] ? 2'd2 : bus.id_req_num;
        ret_e = bus.rob_retire_num[1] ? 2'd2 : bus.rob_retire_num;
        grant = '0;
        rb = '0;
        state_n = state;
        rem_n = rem;
        rem_sum = '0;
        if (state == IDLE) begin
            if (bus.br_mispredict) begin
                rem_n = bus.rob_squash_num;
                state_n = (bus.rob_squash_num != '0) ? RECOVER : IDLE;
            end else begin
                grant = (count < CNT_W'(req_e)) ? count[1:0] : req_e;
            end
        end else begin
            rb = (rem >= CNT_W'(2)) ? 2'd2 : rem[1:0];
            rem_sum = {1'b0, rem} - (CNT_W+1)'(rb) + (bus.br_mispredict ? {1'b0, bus.rob_squash_num} : '0);
            rem_n = rem_sum[CNT_W] ? '1 : rem_sum[CNT_W-1:0];
            state_n = (rem_n == '0) ? IDLE : RECOVER;
        end
        cnt_sum = {1'b0, count} - (CNT_W+1)'(grant) + (CNT_W+1)'(ret_e) + (CNT_W+1)'(rb);
    end

    // state, remaining squash work, clamped free count and sticky overflow flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rem <= '0;
            count <= CNT_W'(FL_DEPTH);
            err <= 1'b0;
        end else begin
            state <= state_n;
            rem <= rem_n;
            count <= (cnt_sum > (CNT_W+1)'(FL_DEPTH)) ? CNT_W'(FL_DEPTH) : cnt_sum[CNT_W-1:0];
            err <= err | (cnt_sum > (CNT_W+1)'(FL_DEPTH));
        end
    end

    assign bus.id_dispatch_num = grant;
    assign bus.fl_rollback_num = rb;
    assign bus.id_stall = grant < req_e;
    assign bus.fl_recovering = state == RECOVER;
    assign bus.fl_free_count = count;
    assign bus.fl_overflow_err = err;
endmodule

// File: tb/tb_fl_alloc_ctrl.sv
// tb_fl_alloc_ctrl: directed and randomized checks of the free-list allocation controller
module tb_fl_alloc_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    fl_alloc_ctrl_if bus ();
    fl_alloc_ctrl dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail = 0;
    int m_cnt, m_rem;
    bit m_err;
    int e_grant, e_rb, e_stall, e_rec;
    int s_req, s_ret, s_sq;
    bit s_br;

    function automatic int eff(input int v);
        return v > 2 ? 2 : v;
    endfunction

    task automatic model_reset();
        m_cnt = 64;
        m_rem = 0;
        m_err = 0;
    endtask

    // entered at posedge+1; drives inputs, predicts outputs, returns at posedge+4
    task automatic apply(input int req, input int ret, input bit br, input int sq);
        s_req = req; s_ret = ret; s_br = br; s_sq = sq;
        bus.id_req_num = 2'(req);
        bus.rob_retire_num = 2'(ret);
        bus.br_mispredict = br;
        bus.rob_squash_num = 7'(sq);
        e_rec = m_rem > 0;
        e_rb = m_rem > 0 ? (m_rem < 2 ? m_rem : 2) : 0;
        e_grant = (m_rem > 0 || br) ? 0 : (eff(req) < m_cnt ? eff(req) : m_cnt);
        e_stall = e_grant < eff(req);
        #3;
    endtask

    task automatic advance();
        int nxt;
        @(posedge clock);
        nxt = m_cnt - e_grant + eff(s_ret) + e_rb;
        if (nxt > 64) begin
            m_cnt = 64;
            m_err = 1;
        end else m_cnt = nxt;
        if (m_rem > 0) begin
            m_rem = m_rem - e_rb + (s_br ? s_sq : 0);
            if (m_rem > 127) m_rem = 127;
        end else if (s_br) m_rem = s_sq;
        #1;
    endtask

    task automatic test_reset();
        bus.id_req_num = 0; bus.rob_retire_num = 0; bus.br_mispredict = 0; bus.rob_squash_num = 0;
        @(posedge clock); #1;
        n_checks++; if (bus.fl_free_count !== 7'd64) begin n_fail++; $display("FAIL reset_count: got %0d expected 64", bus.fl_free_count); end
        n_checks++; if (bus.fl_overflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b expected 0", bus.fl_overflow_err); end
        n_checks++; if (bus.fl_recovering !== 1'b0 || bus.fl_rollback_num !== 2'd0) begin n_fail++; $display("FAIL reset_rec: got rec %0b rb %0d expected 0 0", bus.fl_recovering, bus.fl_rollback_num); end
        n_checks++; if (bus.id_dispatch_num !== 2'd0 || bus.id_stall !== 1'b0) begin n_fail++; $display("FAIL reset_grant: got %0d stall %0b expected 0 0", bus.id_dispatch_num, bus.id_stall); end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_drain();
        for (int i = 0; i < 32; i++) begin
            apply(2, 0, 0, 0);
            n_checks++; if (bus.id_dispatch_num !== 2'd2 || bus.fl_free_count !== 7'(64 - 2*i)) begin n_fail++; $display("FAIL drain_%0d: got grant %0d count %0d expected 2 %0d", i, bus.id_dispatch_num, bus.fl_free_count, 64 - 2*i); end
            advance();
        end
        apply(2, 0, 0, 0);
        n_checks++; if (bus.id_stall !== 1'b1 || bus.id_dispatch_num !== 2'd0 || bus.fl_free_count !== 7'd0) begin n_fail++; $display("FAIL drain_empty: got stall %0b grant %0d count %0d expected 1 0 0", bus.id_stall, bus.id_dispatch_num, bus.fl_free_count); end
        advance();
    endtask

    task automatic test_low_count();
        apply(0, 1, 0, 0);
        advance();
        apply(2, 2, 0, 0);
        n_checks++; if (bus.id_dispatch_num !== 2'd1 || bus.id_stall !== 1'b1 || bus.fl_free_count !== 7'd1) begin n_fail++; $display("FAIL low_grant: got grant %0d stall %0b count %0d expected 1 1 1", bus.id_dispatch_num, bus.id_stall, bus.fl_free_count); end
        advance();
        apply(0, 0, 0, 0);
        n_checks++; if (bus.fl_free_count !== 7'd2) begin n_fail++; $display("FAIL low_next: got %0d expected 2", bus.fl_free_count); end
        advance();
    endtask

    task automatic test_recover();
        int rb_exp[3] = '{2, 2, 1};
        for (int i = 0; i < 19; i++) begin
            apply(0, 2, 0, 0);
            advance();
        end
        apply(2, 0, 1, 5);
        n_checks++; if (bus.id_dispatch_num !== 2'd0 || bus.fl_free_count !== 7'd40 || bus.id_stall !== 1'b1) begin n_fail++; $display("FAIL rec_start: got grant %0d count %0d stall %0b expected 0 40 1", bus.id_dispatch_num, bus.fl_free_count, bus.id_stall); end
        advance();
        for (int k = 0; k < 3; k++) begin
            apply(2, 0, 0, 0);
            n_checks++; if (bus.fl_recovering !== 1'b1 || bus.id_dispatch_num !== 2'd0 || bus.fl_rollback_num !== 2'(rb_exp[k])) begin n_fail++; $display("FAIL rec_step_%0d: got rec %0b grant %0d rb %0d expected 1 0 %0d", k, bus.fl_recovering, bus.id_dispatch_num, bus.fl_rollback_num, rb_exp[k]); end
            advance();
        end
        apply(0, 0, 0, 0);
        n_checks++; if (bus.fl_recovering !== 1'b0 || bus.fl_free_count !== 7'd45) begin n_fail++; $display("FAIL rec_done: got rec %0b count %0d expected 0 45", bus.fl_recovering, bus.fl_free_count); end
        advance();
    endtask

    task automatic test_double_mispredict();
        int total = 0;
        apply(0, 0, 1, 5);
        advance();
        apply(0, 0, 0, 0);
        total += int'(bus.fl_rollback_num);
        advance();
        apply(0, 0, 1, 4);
        n_checks++; if (bus.fl_recovering !== 1'b1 || bus.fl_rollback_num !== 2'd2) begin n_fail++; $display("FAIL dbl_second: got rec %0b rb %0d expected 1 2", bus.fl_recovering, bus.fl_rollback_num); end
        total += int'(bus.fl_rollback_num);
        advance();
        for (int k = 0; k < 10; k++) begin
            apply(0, 0, 0, 0);
            if (!bus.fl_recovering) break;
            total += int'(bus.fl_rollback_num);
            advance();
        end
        n_checks++; if (total != 9 || bus.fl_recovering !== 1'b0 || bus.fl_free_count !== 7'd54) begin n_fail++; $display("FAIL dbl_total: got total %0d rec %0b count %0d expected 9 0 54", total, bus.fl_recovering, bus.fl_free_count); end
        advance();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) begin
            apply(0, 2, 0, 0);
            advance();
        end
        apply(0, 1, 0, 0);
        n_checks++; if (bus.fl_free_count !== 7'd64 || bus.fl_overflow_err !== 1'b0) begin n_fail++; $display("FAIL ovf_pre: got count %0d err %0b expected 64 0", bus.fl_free_count, bus.fl_overflow_err); end
        advance();
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 0);
            n_checks++; if (bus.fl_free_count !== 7'd64 || bus.fl_overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_hold_%0d: got count %0d err %0b expected 64 1", i, bus.fl_free_count, bus.fl_overflow_err); end
            advance();
        end
    endtask

    task automatic test_reset_mid_recover();
        apply(2, 0, 0, 0);
        advance();
        apply(0, 0, 1, 10);
        advance();
        apply(0, 0, 0, 0);
        n_checks++; if (bus.fl_recovering !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got rec %0b expected 1", bus.fl_recovering); end
        #1 reset = 1'b1;
        #1;
        n_checks++; if (bus.fl_recovering !== 1'b0 || bus.fl_rollback_num !== 2'd0 || bus.fl_free_count !== 7'd64 || bus.fl_overflow_err !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got rec %0b rb %0d count %0d err %0b expected 0 0 64 0", bus.fl_recovering, bus.fl_rollback_num, bus.fl_free_count, bus.fl_overflow_err); end
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_saturate();
        int cycles = 0;
        apply(0, 0, 1, 127);
        advance();
        apply(0, 0, 1, 127);
        advance();
        for (int k = 0; k < 100; k++) begin
            apply(0, 0, 0, 0);
            if (!bus.fl_recovering) break;
            cycles++;
            advance();
        end
        n_checks++; if (cycles != 64) begin n_fail++; $display("FAIL sat_cycles: got %0d expected 64", cycles); end
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            apply(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom_range(0, 7) == 0, int'($urandom_range(0, 12)));
            n_checks++; if (bus.id_dispatch_num !== 2'(e_grant)) begin n_fail++; $display("FAIL rnd_grant_%0d: got %0d expected %0d", i, bus.id_dispatch_num, e_grant); end
            n_checks++; if (bus.fl_rollback_num !== 2'(e_rb)) begin n_fail++; $display("FAIL rnd_rb_%0d: got %0d expected %0d", i, bus.fl_rollback_num, e_rb); end
            n_checks++; if (bus.id_stall !== 1'(e_stall) || bus.fl_recovering !== 1'(e_rec)) begin n_fail++; $display("FAIL rnd_flags_%0d: got stall %0b rec %0b expected %0d %0d", i, bus.id_stall, bus.fl_recovering, e_stall, e_rec); end
            n_checks++; if (bus.fl_free_count !== 7'(m_cnt) || bus.fl_overflow_err !== m_err) begin n_fail++; $display("FAIL rnd_count_%0d: got %0d err %0b expected %0d %0b", i, bus.fl_free_count, bus.fl_overflow_err, m_cnt, m_err); end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_drain();
        test_low_count();
        test_recover();
        test_double_mispredict();
        test_overflow();
        test_reset_mid_recover();
        test_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
